// File: rtl/tft_word_feeder.sv
// Word FIFO feeding a TFT SPI serializer: one word is popped per dataClk rise, and FILL is sent when the FIFO is empty.
// Optional macro TFT_FEEDER_UNDERRUN_CNT_EN adds a saturating underrun_count output.
module tft_word_feeder #(
  parameter int          DEPTH = 16,
  parameter logic [15:0] FILL  = 16'h0000,
  localparam int         AW    = $clog2(DEPTH)
) (
  input  logic          SPI_CLK,
  input  logic          reset,
  input  logic [15:0]   wr_data,
  input  logic          wr_en,
  input  logic          dataClk,
  output logic [15:0]   data,
  output logic          full,
  output logic          empty,
  output logic [AW:0]   level,
  output logic          overflow,
`ifdef TFT_FEEDER_UNDERRUN_CNT_EN
  output logic          underrun,
  output logic [7:0]    underrun_count
`else
  output logic          underrun
`endif
);

  logic [15:0]   mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          strb_q;
  logic          boundary;
  logic          pop;
  logic          push;
  logic          drop;
  logic          starve;
  logic [AW:0]   level_next;

  // A pop at a word boundary frees a slot, so a write to a full FIFO in that same cycle is still accepted.
  always_comb begin
    boundary   = dataClk & ~strb_q;
    pop        = boundary & ~empty;
    starve     = boundary & empty;
    push       = wr_en & (~full | pop);
    drop       = wr_en & ~push;
    level_next = level + (AW+1)'(push) - (AW+1)'(pop);
  end

  always_ff @(posedge SPI_CLK) begin
    if (push) mem[wr_ptr] <= wr_data;
  end

  always_ff @(posedge SPI_CLK or posedge reset) begin
    if (reset) begin
      strb_q   <= 1'b1;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      level    <= '0;
      empty    <= 1'b1;
      full     <= 1'b0;
      data     <= FILL;
      overflow <= 1'b0;
      underrun <= 1'b0;
    end else begin
      strb_q   <= dataClk;
      overflow <= drop;
      underrun <= starve;
      level    <= level_next;
      empty    <= (level_next == '0);
      full     <= (level_next == (AW+1)'(DEPTH));
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
        data   <= mem[rd_ptr];
      end else if (starve) begin
        data   <= FILL;
      end
    end
  end

`ifdef TFT_FEEDER_UNDERRUN_CNT_EN
  always_ff @(posedge SPI_CLK or posedge reset) begin
    if (reset) begin
      underrun_count <= 8'd0;
    end else if (starve && underrun_count != 8'hFF) begin
      underrun_count <= underrun_count + 8'd1;
    end
  end
`endif

endmodule

// File: tb/tb_tft_word_feeder.sv
// Randomized self-checking bench for tft_word_feeder; the reference model is a word queue driven by the boundary and accept rules.
module tb_tft_word_feeder;

  localparam int          DEPTH = 16;
  localparam logic [15:0] FILL  = 16'h0000;
  localparam int          AW    = $clog2(DEPTH);

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [15:0]   wr_data = '0;
  logic          wr_en = 1'b0;
  logic          data_clk = 1'b0;
  logic [15:0]   data;
  logic          full;
  logic          empty;
  logic [AW:0]   level;
  logic          overflow;
  logic          underrun;
`ifdef TFT_FEEDER_UNDERRUN_CNT_EN
  logic [7:0]    underrun_count;
`endif

  tft_word_feeder #(.DEPTH(DEPTH), .FILL(FILL)) dut (
    .SPI_CLK(clk),
    .reset(reset),
    .wr_data(wr_data),
    .wr_en(wr_en),
    .dataClk(data_clk),
    .data(data),
    .full(full),
    .empty(empty),
    .level(level),
    .overflow(overflow),
`ifdef TFT_FEEDER_UNDERRUN_CNT_EN
    .underrun(underrun),
    .underrun_count(underrun_count)
`else
    .underrun(underrun)
`endif
  );

  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_errors = 0;
  logic [15:0] q[$];
  logic [15:0] m_data;
  bit          m_strb;
  int          m_ucnt;
  int          n_ovf;
  int          n_und;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    n_checks++;
    if (observed !== expected) begin
      n_errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", tag, observed, expected, $time);
    end
  endtask

  task automatic modelReset();
    q.delete();
    m_data = FILL;
    m_strb = 1'b1;
    m_ucnt = 0;
  endtask

  task automatic checkState(input bit exp_ovf, input bit exp_und);
    checkOutput("data", 32'(data), 32'(m_data));
    checkOutput("level", 32'(level), 32'(q.size()));
    checkOutput("empty", 32'(empty), 32'(q.size() == 0));
    checkOutput("full", 32'(full), 32'(q.size() == DEPTH));
    checkOutput("overflow", 32'(overflow), 32'(exp_ovf));
    checkOutput("underrun", 32'(underrun), 32'(exp_und));
`ifdef TFT_FEEDER_UNDERRUN_CNT_EN
    checkOutput("underrun_count", 32'(underrun_count), 32'(m_ucnt));
`endif
  endtask

  // Called one time unit after a rising edge; drives one cycle and checks the result just after the next edge.
  task automatic applyStimulus(input bit we, input logic [15:0] wd, input bit dc);
    bit bnd, pop, acc, exp_ovf, exp_und;
    wr_en    = we;
    wr_data  = wd;
    data_clk = dc;
    bnd     = dc && !m_strb;
    pop     = bnd && (q.size() != 0);
    acc     = we && ((q.size() < DEPTH) || pop);
    exp_ovf = we && !acc;
    exp_und = bnd && (q.size() == 0);
    if (pop) m_data = q.pop_front();
    else if (exp_und) m_data = FILL;
    if (acc) q.push_back(wd);
    m_strb = dc;
    if (exp_und && m_ucnt < 255) m_ucnt++;
    if (exp_ovf) n_ovf++;
    if (exp_und) n_und++;
    @(posedge clk);
    #1;
    checkState(exp_ovf, exp_und);
  endtask

  task automatic doReset(input bit dc);
    reset    = 1'b1;
    wr_en    = 1'b0;
    data_clk = dc;
    modelReset();
    repeat (2) @(posedge clk);
    #1;
    checkState(1'b0, 1'b0);
    reset = 1'b0;
  endtask

  initial begin
    modelReset();
    doReset(1'b0);

    // Two words out in order, then empty.
    applyStimulus(1'b1, 16'hA5A5, 1'b0);
    applyStimulus(1'b1, 16'h1234, 1'b0);
    applyStimulus(1'b0, 16'h0000, 1'b1);
    checkOutput("first_word", 32'(data), 32'h0000A5A5);
    applyStimulus(1'b0, 16'h0000, 1'b0);
    applyStimulus(1'b0, 16'h0000, 1'b1);
    checkOutput("second_word", 32'(data), 32'h00001234);
    checkOutput("empty_after", 32'(empty), 32'h1);

    // Underrun on an empty FIFO, combined with a write that must be stored.
    applyStimulus(1'b0, 16'h0000, 1'b0);
    n_und = 0;
    applyStimulus(1'b1, 16'hBEEF, 1'b1);
    applyStimulus(1'b0, 16'h0000, 1'b1);
    checkOutput("underrun_pulses", 32'(n_und), 32'd1);

    // Fill past capacity: exactly one dropped write.
    doReset(1'b0);
    n_ovf = 0;
    for (int i = 1; i <= DEPTH + 1; i++) applyStimulus(1'b1, 16'(i), 1'b0);
    checkOutput("overflow_once", 32'(n_ovf), 32'd1);
    checkOutput("full_level", 32'(level), 32'(DEPTH));

    // Full FIFO with a write in the boundary cycle: no overflow, level stays DEPTH.
    n_ovf = 0;
    applyStimulus(1'b1, 16'h7777, 1'b1);
    checkOutput("pop_write_level", 32'(level), 32'(DEPTH));
    checkOutput("pop_write_ovf", 32'(n_ovf), 32'd0);
    for (int i = 0; i < DEPTH; i++) begin
      applyStimulus(1'b0, 16'h0000, 1'b0);
      applyStimulus(1'b0, 16'h0000, 1'b1);
    end
    checkOutput("last_word", 32'(data), 32'h00007777);

    // dataClk held high through reset release must not create a boundary.
    doReset(1'b1);
    n_und = 0;
    repeat (3) applyStimulus(1'b0, 16'h0000, 1'b1);
    checkOutput("no_boundary_held", 32'(n_und), 32'd0);
    applyStimulus(1'b0, 16'h0000, 1'b0);
    applyStimulus(1'b0, 16'h0000, 1'b1);
    checkOutput("boundary_after_fall", 32'(n_und), 32'd1);

    // Asynchronous reset with five words stored.
    applyStimulus(1'b1, 16'h1111, 1'b0);
    applyStimulus(1'b1, 16'h2222, 1'b1);
    for (int i = 0; i < 4; i++) applyStimulus(1'b1, 16'(16'h3000 + i), 1'b0);
    checkOutput("pre_reset_level", 32'(level), 32'd5);
    #2 reset = 1'b1;
    #1;
    checkOutput("async_level", 32'(level), 32'd0);
    checkOutput("async_empty", 32'(empty), 32'd1);
    checkOutput("async_data", 32'(data), 32'(FILL));
    doReset(1'b0);

    // Randomized traffic with shifting write/read bias to visit full and empty.
    for (int phase = 0; phase < 4; phase++) begin
      for (int i = 0; i < 150; i++) begin
        bit we, dc;
        we = ($urandom_range(0, 99) < ((phase % 2 == 0) ? 80 : 20));
        dc = ($urandom_range(0, 99) < ((phase % 2 == 0) ? 20 : 70));
        applyStimulus(we, 16'($urandom), dc);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/tft_word_feeder.md
TFT_WORD_FEEDER -- requirements
Module: tft_word_feeder

Interface
REQ-001 Parameter DEPTH, default 16, FIFO depth in 16-bit words; SHALL be a power of two, 4..256.
REQ-002 Parameter FILL, default 16'h0000, word SHALL be presented on data when a word boundary finds the FIFO empty.
REQ-003 Port SPI_CLK  in  1  sole clock; all state SHALL update on its rising edge.
REQ-004 Port reset  in  1  asynchronous, active-high reset.
REQ-005 Port wr_data  in  16  word to enqueue.
REQ-006 Port wr_en  in  1  enqueue request, one word per cycle.
REQ-007 Port dataClk  in  1  word-boundary strobe from the downstream SPI serializer; high during the first half of each 16-bit word.
REQ-008 Port data  out  16  registered word presented to the serializer.
REQ-009 Port full  out  1  FIFO holds DEPTH words.
REQ-010 Port empty  out  1  FIFO holds 0 words.
REQ-011 Port level  out  log2(DEPTH)+1  current occupancy.
REQ-012 Port overflow  out  1  one-cycle pulse for a dropped write.
REQ-013 Port underrun  out  1  one-cycle pulse when FILL is substituted.

Function
REQ-014 dataClk SHALL be sampled into register strb_q each cycle; a word boundary SHALL be the cycle where dataClk=1 and strb_q=0.
REQ-015 At a word boundary with empty=0, the oldest FIFO word SHALL be loaded into data on that clock edge (one-cycle latency from sampled rise) and removed.
REQ-016 At a word boundary with empty=1, data SHALL load FILL and underrun SHALL pulse high for exactly that cycle.
REQ-017 data SHALL hold its value in all non-boundary cycles.
REQ-018 A write SHALL be accepted when wr_en=1 and (full=0 or a pop occurs in the same cycle).
REQ-019 A write with wr_en=1, full=1 and no same-cycle pop SHALL be dropped and overflow SHALL pulse high for that cycle; FIFO contents are unchanged.
REQ-020 Write with same-cycle boundary while empty=1: no fall-through; FILL SHALL be loaded, underrun SHALL pulse, and the written word SHALL be stored (level becomes 1).
REQ-021 Write and pop in the same cycle with 0<level<DEPTH: level SHALL be unchanged.
REQ-022 Read/write pointers SHALL be log2(DEPTH) bits wide and wrap modulo DEPTH; level SHALL never exceed DEPTH or go below 0.
REQ-023 full, empty and level SHALL be registered and consistent with each other in every cycle.
REQ-024 Words SHALL leave in strict write order.

Reset
REQ-025 While reset=1: data=FILL, level=0, empty=1, full=0, overflow=0, underrun=0, pointers=0.
REQ-026 strb_q SHALL reset to 1, so a dataClk already high at reset release SHALL NOT cause a boundary.
REQ-027 Reset asserted mid-operation SHALL discard all stored words immediately (asynchronously).

Configuration
REQ-028 Macro TFT_FEEDER_UNDERRUN_CNT_EN defined: SHALL add output underrun_count (8 bits, reset 0), incremented on each underrun pulse, saturating at 255, cleared only by reset.
REQ-029 Macro TFT_FEEDER_UNDERRUN_CNT_EN undefined: underrun_count port and its logic SHALL be absent; all other behaviour SHALL be identical.

Verification
REQ-030 Reset, write 16'hA5A5, 16'h1234; two dataClk rises -> data=16'hA5A5 then 16'h1234 one cycle after each sampled rise; empty=1 afterwards.
REQ-031 Empty FIFO, dataClk rise -> data=FILL (16'h0000), underrun high exactly one cycle; with macro, underrun_count=1.
REQ-032 DEPTH=16, write 17 words with no boundaries -> full=1, level=16, overflow pulses once on 17th write; later pops return words 1..16 only.
REQ-033 Full FIFO, wr_en=1 in the boundary cycle -> pop and write both occur, level stays 16, no overflow pulse.
REQ-034 Release reset with dataClk=1 held -> no load, underrun stays 0 until dataClk falls and rises again.
REQ-035 Assert reset with level=5 mid-stream -> level=0, empty=1 and data=FILL immediately, without waiting for a clock edge.
